uart_word_assembler: RTL and testbench

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

---
 rtl/uart_wa_pkg.sv | 18 +
 rtl/uart_wa_timeout.sv | 33 +++
 rtl/uart_word_assembler.sv | 122 ++++++++++++
 tb/tb_uart_word_assembler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_wa_pkg.sv
// Shared types and defaults for the UART word assembler (slot state encoding,
// default sizing constants, counter-width helper).
package uart_wa_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int DEFAULT_WORD_BYTES     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_wa_timeout.sv
// Inter-byte timeout counter: flags expiry when a partial word has seen no byte
// for TIMEOUT_CYCLES cycles. Only instantiated when UART_WA_TIMEOUT_EN is defined.
module uart_wa_timeout
  import uart_wa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_rx_done,
  output logic o_expire
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  // A byte arriving in the expiry cycle wins: no expiry is reported.
  assign o_expire = i_active && !i_rx_done && (cnt == LAST_CNT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_rx_done || !i_active || o_expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART bytes little-endian into WORD_BYTES-wide words behind a one-entry
// output slot. Optional inter-byte timeout selected by macro UART_WA_TIMEOUT_EN.
module uart_word_assembler
  import uart_wa_pkg::*;
#(
  parameter int WORD_BYTES     = DEFAULT_WORD_BYTES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rx_done,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_ready,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_valid,
  output logic                    o_overrun,
  output logic                    o_timeout_tick
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BUF_W  = WORD_W - 8;
  localparam int BCNT_W = cnt_width(WORD_BYTES);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);

  logic [BCNT_W-1:0] byte_cnt;
  logic [BUF_W-1:0]  asm_buf;
  logic [WORD_W-1:0] shifted;
  logic              word_done;
  logic              load_word;
  logic              overrun_set;
  logic              expire;
  slot_state_e       state_q;
  slot_state_e       state_d;

  assign word_done = i_rx_done && (byte_cnt == LAST_BYTE);

  // New bytes enter at the top and move down, so after WORD_BYTES-1 bytes the
  // first one sits in bits [7:0]; {new byte, buffer} is then the full word.
  assign shifted = {i_rx_data, asm_buf};

`ifdef UART_WA_TIMEOUT_EN
  uart_wa_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_active  (byte_cnt != '0),
    .i_rx_done (i_rx_done),
    .o_expire  (expire)
  );
  assign o_timeout_tick = expire;
`else
  // Feature compiled out: partial words persist and the tick never fires.
  assign expire         = 1'b0;
  assign o_timeout_tick = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt <= '0;
      asm_buf  <= '0;
    end else if (i_rx_done) begin
      if (word_done) begin
        byte_cnt <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
        asm_buf  <= shifted[WORD_W-1:8];
      end
    end else if (expire) begin
      byte_cnt <= '0;
    end
  end

  // Output handshake: o_word is offered while o_valid=1 and is consumed on any
  // cycle with i_ready=1; until then o_word is held and a completing word is
  // dropped (setting o_overrun). A word completing in the consuming cycle
  // replaces the consumed one and o_valid stays high.
  always_comb begin
    state_d     = state_q;
    load_word   = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (word_done) begin
          state_d   = FULL;
          load_word = 1'b1;
        end
      end
      FULL: begin
        if (word_done) begin
          if (i_ready) begin
            load_word = 1'b1;
          end else begin
            overrun_set = 1'b1;
          end
        end else if (i_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= EMPTY;
      o_word    <= '0;
      o_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_word) begin
        o_word <= shifted;
      end
      if (overrun_set) begin
        o_overrun <= 1'b1;
      end
    end
  end

  assign o_valid = (state_q == FULL);

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed, table-driven bench for uart_word_assembler (WORD_BYTES=4,
// TIMEOUT_CYCLES=10); timeout sequence chosen by UART_WA_TIMEOUT_EN.
module tb_uart_word_assembler;

  logic        clk;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        ready;
  logic [31:0] word;
  logic        valid;
  logic        overrun;
  logic        tick;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic        exp_overrun;
  } vec_t;

  vec_t vecs[$];

  uart_word_assembler #(
    .WORD_BYTES    (4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_rx_done      (rx_done),
    .i_rx_data      (rx_data),
    .i_ready        (ready),
    .o_word         (word),
    .o_valid        (valid),
    .o_overrun      (overrun),
    .o_timeout_tick (tick)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic d, input logic [7:0] b, input logic r);
    rx_done = d;
    rx_data = b;
    ready   = r;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic add(input logic d, input logic [7:0] b, input logic r,
                     input logic ev, input logic [31:0] ew, input logic eo);
    vec_t v;
    v.rx_done = d; v.rx_data = b; v.ready = r;
    v.exp_valid = ev; v.exp_word = ew; v.exp_overrun = eo;
    vecs.push_back(v);
  endtask

  int ticks;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; ready = 1'b0;
    #1;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_word", word, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single word, consumer ready: valid for exactly one cycle.
    add(1, 8'h78, 1, 0, 32'h0, 0);
    add(1, 8'h56, 1, 0, 32'h0, 0);
    add(1, 8'h34, 1, 0, 32'h0, 0);
    add(1, 8'h12, 1, 1, 32'h12345678, 0);
    add(0, 8'h00, 1, 0, 32'h12345678, 0);
    add(0, 8'h00, 1, 0, 32'h12345678, 0);
    // Slot full, consume and complete in the same cycle.
    add(1, 8'h44, 0, 0, 32'h12345678, 0);
    add(1, 8'h33, 0, 0, 32'h12345678, 0);
    add(1, 8'h22, 0, 0, 32'h12345678, 0);
    add(1, 8'h11, 0, 1, 32'h11223344, 0);
    add(0, 8'h00, 0, 1, 32'h11223344, 0);
    add(1, 8'hBE, 0, 1, 32'h11223344, 0);
    add(1, 8'hBA, 0, 1, 32'h11223344, 0);
    add(1, 8'hFE, 0, 1, 32'h11223344, 0);
    add(1, 8'hCA, 1, 1, 32'hCAFEBABE, 0);
    add(0, 8'h00, 1, 0, 32'hCAFEBABE, 0);
    // Overrun: second word dropped while slot is held.
    add(1, 8'h78, 0, 0, 32'hCAFEBABE, 0);
    add(1, 8'h56, 0, 0, 32'hCAFEBABE, 0);
    add(1, 8'h34, 0, 0, 32'hCAFEBABE, 0);
    add(1, 8'h12, 0, 1, 32'h12345678, 0);
    add(0, 8'h00, 0, 1, 32'h12345678, 0);
    add(1, 8'hDD, 0, 1, 32'h12345678, 0);
    add(1, 8'hCC, 0, 1, 32'h12345678, 0);
    add(1, 8'hBB, 0, 1, 32'h12345678, 0);
    add(1, 8'hAA, 0, 1, 32'h12345678, 1);
    add(0, 8'h00, 1, 0, 32'h12345678, 1);
    add(0, 8'h00, 0, 0, 32'h12345678, 1);
    // Assembly restarted at byte 0 after the dropped word; overrun is sticky.
    add(1, 8'h01, 0, 0, 32'h12345678, 1);
    add(1, 8'h02, 0, 0, 32'h12345678, 1);
    add(1, 8'h03, 0, 0, 32'h12345678, 1);
    add(1, 8'h04, 0, 1, 32'h04030201, 1);
    add(0, 8'h00, 1, 0, 32'h04030201, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rx_done, vecs[i].rx_data, vecs[i].ready);
      check($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_word", i), word, vecs[i].exp_word);
      check($sformatf("v%0d_overrun", i), {31'd0, overrun}, {31'd0, vecs[i].exp_overrun});
      check($sformatf("v%0d_tick", i), {31'd0, tick}, 32'd0);
    end

    // Fill the slot, start a word, then reset mid-word.
    step(1, 8'h0A, 0); step(1, 8'h0B, 0); step(1, 8'h0C, 0); step(1, 8'h0D, 0);
    check("pre_reset_word", word, 32'h0D0C0B0A);
    step(1, 8'h99, 0); step(1, 8'h98, 0); step(1, 8'h97, 0);
    reset = 1'b1;
    #1;
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_word", word, 32'd0);
    check("midreset_overrun", {31'd0, overrun}, 32'd0);
    check("midreset_tick", {31'd0, tick}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 8'h11, 1); step(1, 8'h22, 1); step(1, 8'h33, 1);
    check("postreset_partial_valid", {31'd0, valid}, 32'd0);
    step(1, 8'h44, 1);
    check("postreset_word", word, 32'h44332211);
    check("postreset_valid", {31'd0, valid}, 32'd1);
    step(0, 8'h00, 1);
    check("postreset_drain", {31'd0, valid}, 32'd0);

`ifdef UART_WA_TIMEOUT_EN
    // Two bytes then silence: exactly one tick, and the partial word is gone.
    step(1, 8'hA1, 1); step(1, 8'hA2, 1);
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      if (tick) ticks++;
      step(0, 8'h00, 1);
    end
    check("timeout_tick_count", ticks, 32'd1);
    step(1, 8'h01, 1); step(1, 8'h02, 1); step(1, 8'h03, 1); step(1, 8'h04, 1);
    check("timeout_next_word", word, 32'h04030201);
    check("timeout_next_valid", {31'd0, valid}, 32'd1);
    // A byte landing in the expiry cycle wins over the timeout.
    step(0, 8'h00, 1);
    step(1, 8'hB1, 1);
    for (int c = 0; c < 9; c++) step(0, 8'h00, 1);
    check("expiry_cycle_tick", {31'd0, tick}, 32'd1);
    ticks = 0;
    step(1, 8'hB2, 1);
    for (int c = 0; c < 8; c++) begin
      if (tick) ticks++;
      step(0, 8'h00, 1);
    end
    check("byte_wins_no_tick", ticks, 32'd0);
    step(1, 8'hB3, 1);
    step(1, 8'hB4, 1);
    check("byte_wins_word", word, 32'hB4B3B2B1);
`else
    // No timeout: a partial word survives a long idle gap.
    step(1, 8'hAB, 1); step(1, 8'hCD, 1);
    ticks = 0;
    for (int c = 0; c < 2000; c++) begin
      if (tick) ticks++;
      step(0, 8'h00, 1);
    end
    check("no_timeout_tick_count", ticks, 32'd0);
    step(1, 8'hEE, 1);
    check("no_timeout_partial_valid", {31'd0, valid}, 32'd0);
    step(1, 8'hFF, 1);
    check("no_timeout_word", word, 32'hFFEECDAB);
    check("no_timeout_valid", {31'd0, valid}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
